// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the push-button front end of the countdown timer:
// key count, key bit positions and the auto-repeat state encoding.
// -----------------------------------------------------------------------------
package key_pkg;

  localparam int NUM_KEYS = 5;

  // Bit positions of the keys in every key vector.
  localparam int KEY_E = 0;  // enter
  localparam int KEY_U = 1;  // up
  localparam int KEY_D = 2;  // down
  localparam int KEY_L = 3;  // left
  localparam int KEY_R = 4;  // right

  // Auto-repeat state per channel.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-FF synchroniser, debounce counter with press/release
// pulse generation, and an optional auto-repeat FSM.
// Ports:
//   clkin       in  system clock
//   rst_n       in  asynchronous active-low reset
//   key_n       in  raw key, active-low, asynchronous to clkin
//   key_level   out debounced level, 1 = pressed
//   key_press   out one-cycle pulse on an accepted press
//   key_release out one-cycle pulse on an accepted release
//   key_repeat  out one-cycle auto-repeat pulse (0 when REPEAT_EN = 0)
// -----------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int             DW        = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0]  DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0]  DCNT_ONE  = DW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          sample_s;
  logic          st_r;
  logic          st_nxt_s;
  logic [DW-1:0] dcnt_r;
  logic [DW-1:0] dcnt_nxt_s;
  logic          press_r;
  logic          press_nxt_s;
  logic          release_r;
  logic          release_nxt_s;

  // Two-flop synchroniser; idles at released (1) out of reset.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  assign sample_s = ~sync2_r;  // 1 = pressed

  // Debounce decision: a change is accepted on the DEBOUNCE_CYC-th consecutive differing sample.
  always_comb begin
    st_nxt_s      = st_r;
    dcnt_nxt_s    = '0;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    if (sample_s == st_r) begin
      dcnt_nxt_s = '0;
    end else if (dcnt_r == DCNT_LAST) begin
      st_nxt_s      = ~st_r;
      dcnt_nxt_s    = '0;
      press_nxt_s   = sample_s;
      release_nxt_s = ~sample_s;
    end else begin
      dcnt_nxt_s = dcnt_r + DCNT_ONE;
    end
  end

  // Debounce state, counter and registered press/release pulses.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      st_r      <= 1'b0;
      dcnt_r    <= '0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      st_r      <= st_nxt_s;
      dcnt_r    <= dcnt_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
    end
  end

  assign key_level   = st_r;
  assign key_press   = press_r;
  assign key_release = release_r;

  if (REPEAT_EN) begin : g_rpt
    localparam logic [31:0] RD_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RR_LAST  = 32'(REPEAT_RATE - 1);
    localparam logic [31:0] RCNT_ONE = 32'd1;

    rpt_state_e  state_r;
    rpt_state_e  state_nxt_s;
    logic [31:0] rcnt_r;
    logic [31:0] rcnt_nxt_s;
    logic        repeat_r;
    logic        repeat_nxt_s;

    // Repeat FSM. It starts on the same edge that registers the press pulse, so
    // rcnt equals the number of cycles since the pulse became visible; a release
    // always wins and suppresses any repeat in the release cycle.
    always_comb begin
      state_nxt_s  = state_r;
      rcnt_nxt_s   = rcnt_r;
      repeat_nxt_s = 1'b0;
      if (release_nxt_s) begin
        state_nxt_s = IDLE;
        rcnt_nxt_s  = 32'd0;
      end else begin
        case (state_r)
          IDLE: begin
            rcnt_nxt_s = 32'd0;
            if (press_nxt_s) begin
              state_nxt_s = DELAY;
            end else begin
              state_nxt_s = IDLE;
            end
          end
          DELAY: begin
            if (rcnt_r == RD_LAST) begin
              repeat_nxt_s = 1'b1;
              rcnt_nxt_s   = 32'd0;
              state_nxt_s  = RATE;
            end else begin
              rcnt_nxt_s = rcnt_r + RCNT_ONE;
            end
          end
          RATE: begin
            if (rcnt_r == RR_LAST) begin
              repeat_nxt_s = 1'b1;
              rcnt_nxt_s   = 32'd0;
            end else begin
              rcnt_nxt_s = rcnt_r + RCNT_ONE;
            end
          end
          default: begin
            state_nxt_s = IDLE;
            rcnt_nxt_s  = 32'd0;
          end
        endcase
      end
    end

    // Repeat FSM state, counter and registered repeat pulse.
    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        state_r  <= IDLE;
        rcnt_r   <= 32'd0;
        repeat_r <= 1'b0;
      end else begin
        state_r  <= state_nxt_s;
        rcnt_r   <= rcnt_nxt_s;
        repeat_r <= repeat_nxt_s;
      end
    end

    assign key_repeat = repeat_r;
  end else begin : g_no_rpt
    assign key_repeat = 1'b0;
  end

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Front end for the timer's five push-buttons. Each key is synchronised and
// debounced independently; clean press/release pulses and auto-repeat pulses
// (for keys in REPEAT_MASK) feed the timer control FSM directly.
// Ports:
//   clkin       in  system clock (only clock)
//   rst_n       in  asynchronous active-low reset
//   key_n       in  raw keys, active-low; bit 0 enter, 1 up, 2 down, 3 left, 4 right
//   key_level   out debounced levels, 1 = pressed
//   key_press   out one-cycle pulses on accepted presses
//   key_release out one-cycle pulses on accepted releases
//   key_repeat  out one-cycle auto-repeat pulses
// -----------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int                  DEBOUNCE_CYC = 1000000,
  parameter int                  REPEAT_DELAY = 25000000,
  parameter int                  REPEAT_RATE  = 5000000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK  = 5'b00110
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_ch (
      .clkin       (clkin),
      .rst_n       (rst_n),
      .key_n       (key_n[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;
  import key_pkg::*;

  localparam int         DC   = 8;
  localparam int         RD   = 20;
  localparam int         RR   = 6;
  localparam logic [4:0] MASK = 5'b00110;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] key_n = 5'h1F;
  logic [4:0] key_level, key_press, key_release, key_repeat;

  key_debounce #(
    .DEBOUNCE_CYC (DC),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .REPEAT_MASK  (MASK)
  ) dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  always #5 clkin = ~clkin;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: sample history and stable levels.
  logic [4:0] dly0_m, dly1_m;      // raw pressed bits from two and one edges ago
  logic [4:0] hist_m[$];           // last DC samples seen by the debouncer
  logic [4:0] lvl_m, prs_m, rel_m, rpt_m;
  int         press_at[5];

  // Observation counters (from DUT outputs).
  int n_press[5], n_rel[5], n_rpt[5], press_cyc[5];
  int n_act = 0;

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    dly0_m = 5'b0; dly1_m = 5'b0;
    hist_m.delete();
    lvl_m = 5'b0; prs_m = 5'b0; rel_m = 5'b0; rpt_m = 5'b0;
  endtask

  // One active edge: a key's level flips when the last DC samples all disagree with it.
  task automatic model_edge();
    logic [4:0] smp;
    bit         all_diff;
    smp    = dly0_m;
    dly0_m = dly1_m;
    dly1_m = ~key_n;
    hist_m.push_back(smp);
    if (hist_m.size() > DC) void'(hist_m.pop_front());
    prs_m = 5'b0; rel_m = 5'b0; rpt_m = 5'b0;
    for (int i = 0; i < 5; i++) begin
      all_diff = (hist_m.size() == DC);
      for (int k = 0; k < hist_m.size(); k++)
        if (hist_m[k][i] == lvl_m[i]) all_diff = 1'b0;
      if (all_diff) begin
        lvl_m[i] = ~lvl_m[i];
        if (lvl_m[i]) begin prs_m[i] = 1'b1; press_at[i] = cyc; end
        else rel_m[i] = 1'b1;
      end
      if (MASK[i] && lvl_m[i] && (cyc - press_at[i] >= RD) && ((cyc - press_at[i] - RD) % RR == 0))
        rpt_m[i] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk5("level",   key_level,   lvl_m);
    chk5("press",   key_press,   prs_m);
    chk5("release", key_release, rel_m);
    chk5("repeat",  key_repeat,  rpt_m);
  endtask

  task automatic tick();
    @(posedge clkin);
    cyc++;
    if (rst_n) model_edge(); else model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < 5; i++) begin
      if (key_press[i])   begin n_press[i]++; press_cyc[i] = cyc; end
      if (key_release[i]) n_rel[i]++;
      if (key_repeat[i])  n_rpt[i]++;
    end
    if (|{key_level, key_press, key_release, key_repeat}) n_act++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    ticks(hold);
    rst_n = 1'b1;
  endtask

  initial begin
    int t0, base, snap, hold_left[5];
    bit seen;
    for (int i = 0; i < 5; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_rpt[i] = 0; press_cyc[i] = -1; press_at[i] = 0;
    end
    model_reset();

    // Reset state
    #1;
    apply_reset(3);
    ticks(4);

    // Clean press on enter: pulse exactly 10 edges after the fall, no repeat
    key_n[KEY_E] = 1'b0; t0 = cyc;
    ticks(14);
    chki("clean_press_cyc", press_cyc[KEY_E], t0 + 10);
    chki("clean_press_cnt", n_press[KEY_E], 1);
    chki("clean_level", int'(key_level[KEY_E]), 1);
    chki("clean_no_repeat", n_rpt[KEY_E], 0);
    key_n[KEY_E] = 1'b1;
    ticks(14);
    chki("clean_release_cnt", n_rel[KEY_E], 1);

    // Bounce on left: 5 low, 3 high, then hold low
    key_n[KEY_L] = 1'b0; ticks(5);
    key_n[KEY_L] = 1'b1; ticks(3);
    key_n[KEY_L] = 1'b0; t0 = cyc;
    ticks(14);
    chki("bounce_press_cyc", press_cyc[KEY_L], t0 + 10);
    chki("bounce_press_cnt", n_press[KEY_L], 1);
    chki("bounce_no_release", n_rel[KEY_L], 0);
    key_n[KEY_L] = 1'b1;
    ticks(14);

    // Held up key: 7 repeats in the 60 cycles after the press pulse
    key_n[KEY_U] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (key_press[KEY_U]) seen = 1'b1;
    end
    chki("held_press_seen", int'(seen), 1);
    base = n_rpt[KEY_U];
    ticks(60);
    chki("held_repeat_cnt", n_rpt[KEY_U] - base, 7);
    key_n[KEY_U] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (key_release[KEY_U]) seen = 1'b1;
    end
    chki("held_release_seen", int'(seen), 1);
    snap = n_rpt[KEY_U];
    ticks(30);
    chki("held_no_repeat_after_release", n_rpt[KEY_U] - snap, 0);
    chki("held_release_cnt", n_rel[KEY_U], 1);

    // Simultaneous press on down and right
    key_n[KEY_D] = 1'b0; key_n[KEY_R] = 1'b0; t0 = cyc;
    ticks(12);
    chki("simul_down_cyc",  press_cyc[KEY_D], t0 + 10);
    chki("simul_right_cyc", press_cyc[KEY_R], t0 + 10);
    key_n[KEY_D] = 1'b1; key_n[KEY_R] = 1'b1;
    ticks(14);

    // Reset while up is held, then a fresh press after full latency
    key_n[KEY_U] = 1'b0;
    ticks(30);
    chki("rst_pre_level", int'(key_level[KEY_U]), 1);
    apply_reset(3);
    chk5("rst_level_zero", key_level, 5'b0);
    t0 = cyc;
    base = n_press[KEY_U];
    ticks(12);
    chki("rst_repress_cnt", n_press[KEY_U] - base, 1);
    chki("rst_repress_cyc", press_cyc[KEY_U], t0 + 10);
    key_n[KEY_U] = 1'b1;
    ticks(14);

    // Glitch of 7 cycles on enter: no output activity
    snap = n_act;
    key_n[KEY_E] = 1'b0; ticks(7);
    key_n[KEY_E] = 1'b1; ticks(20);
    chki("glitch_no_activity", n_act - snap, 0);

    // Randomised per-key hold times against the model, with one reset midway
    for (int i = 0; i < 5; i++) hold_left[i] = $urandom_range(1, 45);
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold_left[i] == 0) begin
          key_n[i] = ~key_n[i];
          hold_left[i] = $urandom_range(1, 45);
        end else begin
          hold_left[i]--;
        end
      end
      if (n == 1000) apply_reset(2);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
